alu_tx_interface: RTL and testbench

- Sequences the return path of the UART calculator: waits for the RX command parser to flag a complete command, then captures the ALU result.
- Converts the result to signed ASCII decimal and streams it byte-by-byte through the UART transmitter using its start/done handshake.
- Acknowledges the RX parser with `rd` so the parser clears its operands and accepts the next command.

---
 rtl/alu_tx_interface_pkg.sv | 23 ++
 rtl/alu_tx_interface_bin_to_ascii_dec.sv | 53 +++++
 rtl/alu_tx_interface.sv | 86 ++++++++
 tb/tb_alu_tx_interface.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_tx_interface_pkg.sv
// alu_tx_interface_pkg: shared ASCII codes, command letters, FSM encoding and a power-of-ten helper
package alu_tx_interface_pkg;
  localparam logic [7:0] ASCII_ZERO  = 8'd48;
  localparam logic [7:0] ASCII_PLUS  = 8'd43;
  localparam logic [7:0] ASCII_MINUS = 8'd45;
  localparam logic [7:0] ASCII_NL    = 8'd10;
  localparam logic [7:0] CMD_F = 8'd102;
  localparam logic [7:0] CMD_S = 8'd115;
  localparam logic [7:0] CMD_O = 8'd111;
  localparam logic [7:0] CMD_D = 8'd100;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CONV = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_ACK  = 3'd4;
  localparam logic [2:0] S_CLR  = 3'd5;
  function automatic int pow10(input int k);
    int p;
    p = 1;
    for (int i = 0; i < 9; i++) p = (i < k) ? p * 10 : p;
    return p;
  endfunction
endpackage

// File: rtl/alu_tx_interface_bin_to_ascii_dec.sv
// bin_to_ascii_dec: sequential repeated-subtraction binary to ASCII decimal converter
// Ports: clk, reset (async active-low), start (load magnitude), magnitude[DBIT-1:0],
//        done (one-cycle pulse when digits are valid), digits[NDIG-1:0][7:0] (index NDIG-1 = MSD)
module bin_to_ascii_dec
  import alu_tx_interface_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int NDIG = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DBIT-1:0]      magnitude,
  output logic                 done,
  output logic [NDIG-1:0][7:0] digits
);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  logic                 run;
  logic [IW-1:0]        idx;
  logic [DBIT-1:0]      rem;
  logic [NDIG-1:0][3:0] d;
  logic [31:0]          w;
  assign w = pow10(int'(idx));
  // One subtraction per cycle at the current weight; a failed compare moves to the next digit,
  // and whatever is left at weight 1 is the units digit.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      run  <= 1'b0;
      done <= 1'b0;
      idx  <= '0;
      rem  <= '0;
      d    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run <= 1'b1;
        idx <= IW'(NDIG - 1);
        rem <= magnitude;
        d   <= '0;
      end else if (run) begin
        if (idx == '0) begin
          d[0] <= rem[3:0];
          run  <= 1'b0;
          done <= 1'b1;
        end else if (32'(rem) >= w) begin
          rem    <= rem - DBIT'(w);
          d[idx] <= d[idx] + 4'd1;
        end else idx <= idx - 1'b1;
      end
    end
  always_comb
    for (int i = 0; i < NDIG; i++) digits[i] = ASCII_ZERO + {4'd0, d[i]};
endmodule

// File: rtl/alu_tx_interface.sv
// alu_tx_interface: latches the ALU result on a complete command and streams it as signed ASCII decimal over UART TX
// Ports: clk, reset (async active-low), rx_empty (command complete), result[DBIT-1:0] (signed ALU output),
//        tx_done_tick (byte sent), tx_start (send din), din[7:0] (byte), rd (ack to RX parser), busy (not IDLE)
module alu_tx_interface
  import alu_tx_interface_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int NDIG = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] result,
  input  logic            tx_done_tick,
  output logic            tx_start,
  output logic [7:0]      din,
  output logic            rd,
  output logic            busy
);
  localparam int BW = $clog2(NDIG + 2);
  logic [2:0]           state;
  logic [DBIT-1:0]      res_q;
  logic [DBIT-1:0]      mag;
  logic                 conv_start;
  logic                 conv_done;
  logic [BW-1:0]        bidx;
  logic [NDIG-1:0][7:0] digits;
  logic [NDIG+1:0][7:0] frame;
  // Negating in DBIT bits maps the most negative value onto itself, which read unsigned is its magnitude.
  assign mag  = res_q[DBIT-1] ? -res_q : res_q;
  assign busy = state != S_IDLE;
  always_comb begin
    frame[0] = res_q[DBIT-1] ? ASCII_MINUS : ASCII_PLUS;
    for (int i = 0; i < NDIG; i++) frame[i+1] = digits[NDIG-1-i];
    frame[NDIG+1] = ASCII_NL;
  end
  bin_to_ascii_dec #(.DBIT(DBIT), .NDIG(NDIG)) u_conv (
    .clk      (clk),
    .reset    (reset),
    .start    (conv_start),
    .magnitude(mag),
    .done     (conv_done),
    .digits   (digits)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= S_IDLE;
      res_q      <= '0;
      conv_start <= 1'b0;
      bidx       <= '0;
      tx_start   <= 1'b0;
      din        <= '0;
      rd         <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      tx_start   <= 1'b0;
      rd         <= 1'b0;
      case (state)
        S_IDLE: if (rx_empty) begin
          res_q      <= result;
          conv_start <= 1'b1;
          state      <= S_CONV;
        end
        S_CONV: if (conv_done) begin
          bidx  <= '0;
          state <= S_SEND;
        end
        S_SEND: begin
          din      <= frame[bidx];
          tx_start <= 1'b1;
          state    <= S_WAIT;
        end
        S_WAIT: if (tx_done_tick) begin
          state <= bidx == BW'(NDIG + 1) ? S_ACK : S_SEND;
          bidx  <= bidx == BW'(NDIG + 1) ? bidx : bidx + 1'b1;
        end
        S_ACK: begin
          rd    <= 1'b1;
          state <= S_CLR;
        end
        // Holding here until the parser drops rx_empty keeps the same command from being sent twice.
        S_CLR: if (!rx_empty) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_tx_interface.sv
// tb_alu_tx_interface: scoreboard bench for alu_tx_interface with a UART TX responder model
module tb_alu_tx_interface;
  logic       clk = 1'b0;
  logic       reset, rx_empty, tx_done_tick, tick_m, spur;
  logic [7:0] result, din;
  logic       tx_start, rd, busy;
  int         n_assert = 0, n_fail = 0;
  int         start_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int         q[$];

  assign tx_done_tick = tick_m | spur;
  always #5 clk = ~clk;

  alu_tx_interface #(.DBIT(8), .NDIG(3)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .result(result), .tx_done_tick(tx_done_tick),
    .tx_start(tx_start), .din(din), .rd(rd), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic void push_frame(input int v);
    int m;
    m = v < 0 ? -v : v;
    q.push_back(v < 0 ? 45 : 43);
    q.push_back(48 + m / 100);
    q.push_back(48 + (m / 10) % 10);
    q.push_back(48 + m % 10);
    q.push_back(10);
  endfunction

  // TX responder: checks each byte against the scoreboard, holds a byte outstanding
  // for 20 cycles, then returns a one-cycle tx_done_tick.
  task automatic monitor();
    int          cnt = 0, cyc = 0, tick_cyc = -100;
    logic        outstanding = 1'b0;
    logic [7:0]  held = '0;
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      cyc++;
      tick_m = 1'b0;
      if (!reset) begin
        outstanding = 1'b0;
        cnt = 0;
        done_cnt = 0;
      end else begin
        if (tx_start) begin
          start_cnt++;
          chk("no_start_while_outstanding", 32'(outstanding), 0);
          if (done_cnt > 0) chk("start_gap_after_done", 32'(cyc - tick_cyc), 2);
          exp = 'x;
          if (q.size() > 0) exp = 32'(q.pop_front());
          chk("din_byte", 32'(din), exp);
          held = din;
          outstanding = 1'b1;
          cnt = 20;
        end else if (outstanding) begin
          chk("din_hold", 32'(din), 32'(held));
          cnt--;
          if (cnt == 0) begin
            tick_m = 1'b1;
            outstanding = 1'b0;
            done_cnt++;
            tick_cyc = cyc;
          end
        end
        if (rd) begin
          rd_cnt++;
          chk("rd_after_all_done", 32'(done_cnt), 5);
          done_cnt = 0;
        end
      end
    end
  endtask

  task automatic wait_rd(input int target);
    int k = 0;
    while (rd_cnt < target && k < 2000) begin
      step(1);
      k++;
    end
    chk("rd_reached", 32'(rd_cnt), 32'(target));
  endtask

  task automatic run_frame(input int v, input bit hold, input bit chg);
    int s0, r0, lat;
    s0 = start_cnt;
    r0 = rd_cnt;
    push_frame(v);
    result = 8'(v);
    rx_empty = 1'b1;
    lat = 0;
    if (chg) begin
      step(2);
      spur = 1'b1;
      step(1);
      spur = 1'b0;
      lat = 3;
    end
    do begin
      step(1);
      lat++;
    end while (!tx_start && lat < 100);
    chk("first_start_latency_ok", 32'(lat <= 30), 1);
    if (chg) result = 8'(-50);
    wait_rd(r0 + 1);
    chk("starts_per_frame", 32'(start_cnt - s0), 5);
    chk("scoreboard_empty", 32'(q.size()), 0);
    if (hold) begin
      step(50);
      chk("no_refire_while_rx_empty", 32'(start_cnt - s0), 5);
      chk("rd_single", 32'(rd_cnt - r0), 1);
      chk("busy_in_clr", 32'(busy), 1);
    end
    rx_empty = 1'b0;
    step(2);
    chk("busy_low_after_drop", 32'(busy), 0);
  endtask

  initial begin
    int s0, r0, k;
    reset = 1'b0;
    rx_empty = 1'b0;
    result = '0;
    spur = 1'b0;
    tick_m = 1'b0;
    fork
      monitor();
    join_none
    step(3);
    chk("reset_tx_start", 32'(tx_start), 0);
    chk("reset_din", 32'(din), 0);
    chk("reset_rd", 32'(rd), 0);
    chk("reset_busy", 32'(busy), 0);
    reset = 1'b1;
    step(2);
    run_frame(42, 0, 0);
    run_frame(-128, 0, 0);
    run_frame(127, 0, 0);
    run_frame(0, 0, 0);
    run_frame(-1, 0, 0);
    s0 = start_cnt;
    spur = 1'b1;
    step(1);
    spur = 1'b0;
    step(5);
    chk("spurious_done_idle", 32'(start_cnt - s0), 0);
    chk("spurious_done_idle_busy", 32'(busy), 0);
    run_frame(99, 0, 1);
    run_frame(55, 1, 0);
    run_frame(7, 0, 0);
    s0 = start_cnt;
    r0 = rd_cnt;
    push_frame(-99);
    result = 8'(-99);
    rx_empty = 1'b1;
    k = 0;
    while (start_cnt < s0 + 3 && k < 500) begin
      step(1);
      k++;
    end
    chk("reached_byte3", 32'(start_cnt - s0), 3);
    step(5);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_tx_start", 32'(tx_start), 0);
    chk("async_reset_din", 32'(din), 0);
    chk("async_reset_rd", 32'(rd), 0);
    chk("async_reset_busy", 32'(busy), 0);
    step(40);
    chk("abort_no_start", 32'(start_cnt - s0), 3);
    chk("abort_no_rd", 32'(rd_cnt - r0), 0);
    q.delete();
    push_frame(-77);
    result = 8'(-77);
    reset = 1'b1;
    wait_rd(r0 + 1);
    chk("fresh_frame_starts", 32'(start_cnt - s0), 8);
    chk("fresh_scoreboard_empty", 32'(q.size()), 0);
    rx_empty = 1'b0;
    step(2);
    chk("final_idle", 32'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
